// File: rtl/vga_scan.sv
// vga_scan: 640x480@60 raster timing that upscales each 80x60 VRAM cell to an 8x8 block.
// Two-tick pipeline: stage 1 issues the VRAM read, stage 2 registers colour and syncs.
module vga_scan #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    output logic        vram_load,
    output logic [12:0] vram_addr,
    input  logic [11:0] vram_data,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        frame_start
);
    localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
    localparam logic [9:0] H_SYNC_S = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SYNC_E = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_S = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SYNC_E = 10'(V_VIS + V_FP + V_SYNC);

    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic        r_vis1;
    logic        r_hs1;
    logic        r_vs1;
    logic [12:0] r_addr;
    logic [11:0] r_rgb;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_fs;

    logic        w_visible;
    logic        w_hs;
    logic        w_vs;
    logic        w_h_last;
    logic        w_v_last;
    logic [12:0] w_row;
    logic [12:0] w_addr;

    assign w_visible = (r_h_cnt < H_VIS_L) && (r_v_cnt < V_VIS_L);
    assign w_hs      = !((r_h_cnt >= H_SYNC_S) && (r_h_cnt < H_SYNC_E));
    assign w_vs      = !((r_v_cnt >= V_SYNC_S) && (r_v_cnt < V_SYNC_E));
    assign w_h_last  = (r_h_cnt == H_LAST);
    assign w_v_last  = (r_v_cnt == V_LAST);

    // Row stride of 80 cells built as 64 + 16 so no multiplier is inferred.
    assign w_row  = {6'd0, r_v_cnt[9:3]};
    assign w_addr = (w_row << 6) + (w_row << 4) + {6'd0, r_h_cnt[9:3]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= 10'd0;
            r_vis1  <= 1'b0;
            r_hs1   <= 1'b1;
            r_vs1   <= 1'b1;
            r_addr  <= 13'd0;
            r_rgb   <= 12'd0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_fs    <= 1'b0;
        end else begin
            // frame_start is a single-clock pulse even when pix_en stays low afterwards.
            r_fs <= 1'b0;
            if (pix_en) begin
                r_fs <= (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);

                if (w_h_last) begin
                    r_h_cnt <= 10'd0;
                    r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
                end else begin
                    r_h_cnt <= r_h_cnt + 10'd1;
                end

                r_vis1 <= w_visible;
                r_addr <= w_visible ? w_addr : 13'd0;
                r_hs1  <= w_hs;
                r_vs1  <= w_vs;

                r_rgb   <= r_vis1 ? vram_data : 12'd0;
                r_hsync <= r_hs1;
                r_vsync <= r_vs1;
            end
        end
    end

    assign vram_load   = r_vis1;
    assign vram_addr   = r_addr;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign red         = r_rgb[11:8];
    assign green       = r_rgb[7:4];
    assign blue        = r_rgb[3:0];
    assign frame_start = r_fs;
endmodule

// File: tb/tb_vga_scan.sv
// Bench for vga_scan: a position-from-tick-count reference model checks the full-size
// scanner; a short-frame instance covers vsync width, frame wrap and frame_start spacing.
module tb_vga_scan;
    localparam int H_TOT = 800;
    localparam int FRAME = 420000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        pix_en;
    logic        vram_load;
    logic [12:0] vram_addr;
    logic [11:0] vram_data;
    logic        hsync;
    logic        vsync;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        frame_start;

    logic [11:0] mem [0:8191];
    logic        mode_const;
    logic [11:0] const_val;
    assign vram_data = mode_const ? const_val : mem[vram_addr];

    logic [28:0] obs;
    assign obs = {vram_load, vram_addr, hsync, vsync, red, green, blue, frame_start};

    vga_scan dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .vram_load(vram_load), .vram_addr(vram_addr), .vram_data(vram_data),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
        .frame_start(frame_start)
    );

    // Short frame: 16 visible lines, 22 lines total = 17600 ticks.
    logic        rst_s;
    logic        load_s;
    logic [12:0] addr_s;
    logic        hsync_s;
    logic        vsync_s;
    logic [3:0]  red_s;
    logic [3:0]  green_s;
    logic [3:0]  blue_s;
    logic        fs_s;
    logic        pix_en_s = 1'b1;
    logic [11:0] data_s = 12'h5A5;

    vga_scan #(.V_VIS(16), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut_s (
        .clk(clk), .rst(rst_s), .pix_en(pix_en_s),
        .vram_load(load_s), .vram_addr(addr_s), .vram_data(data_s),
        .hsync(hsync_s), .vsync(vsync_s), .red(red_s), .green(green_s), .blue(blue_s),
        .frame_start(fs_s)
    );

    int checks   = 0;
    int failures = 0;
    int n_ticks  = 0;

    // Expected pins after n enabled ticks since reset release; en says whether the
    // latest clock edge was an enabled one.
    function automatic logic [28:0] model(int n, logic en);
        int p, h, v;
        logic        load, hs, vs, fs;
        logic [12:0] addr;
        logic [11:0] rgb;
        load = 1'b0; addr = 13'd0; hs = 1'b1; vs = 1'b1; rgb = 12'd0; fs = 1'b0;
        if (n >= 1) begin
            p = (n - 1) % FRAME; h = p % H_TOT; v = p / H_TOT;
            if (h < 640 && v < 480) begin
                load = 1'b1;
                addr = 13'((v / 8) * 80 + h / 8);
            end
            fs = en && (p == 0);
        end
        if (n >= 2) begin
            p = (n - 2) % FRAME; h = p % H_TOT; v = p / H_TOT;
            hs = !(h >= 656 && h < 752);
            vs = !(v >= 490 && v < 492);
            if (h < 640 && v < 480)
                rgb = mode_const ? const_val : mem[(v / 8) * 80 + h / 8];
        end
        return {load, addr, hs, vs, rgb, fs};
    endfunction

    task automatic step(input logic en);
        pix_en = en;
        @(posedge clk);
        #1;
        if (en) n_ticks++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        n_ticks = 0;
    endtask

    task automatic test_reset();
        logic [28:0] exp_v;
        exp_v = {1'b0, 13'd0, 1'b1, 1'b1, 12'd0, 1'b0};
        rst = 1'b0;
        pix_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL reset cyc=%0d got=%h want=%h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_scan();
        logic [28:0] exp_v;
        mode_const = 1'b0;
        for (int i = 0; i < 8192; i++) mem[i] = 12'($urandom);
        do_reset();
        for (int i = 0; i < 7000; i++) begin
            step(1'b1);
            exp_v = model(n_ticks, 1'b1);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL scan n=%0d got=%h want=%h", n_ticks, obs, exp_v);
            end
        end
    endtask

    task automatic test_blank_colour();
        logic [28:0] exp_v;
        mode_const = 1'b1;
        do_reset();
        for (int i = 0; i < 1700; i++) begin
            const_val = ($urandom_range(0, 1) == 0) ? 12'hABC : 12'hFFF;
            step(1'b1);
            exp_v = model(n_ticks, 1'b1);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL blank_colour n=%0d got=%h want=%h", n_ticks, obs, exp_v);
            end
        end
        mode_const = 1'b0;
    endtask

    task automatic test_pix_en();
        logic [28:0] exp_v;
        logic        en;
        do_reset();
        for (int i = 0; i < 12000; i++) begin
            en = (i < 8000) ? (i % 4 == 0) : ($urandom_range(0, 3) == 0);
            step(en);
            exp_v = model(n_ticks, en);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL pix_en i=%0d en=%0b got=%h want=%h", i, en, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [28:0] exp_v;
        logic [28:0] rst_v;
        rst_v = {1'b0, 13'd0, 1'b1, 1'b1, 12'd0, 1'b0};
        do_reset();
        while (n_ticks < 3 * H_TOT + 300) step(1'b1);
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== rst_v) begin
            failures++;
            $display("FAIL reset_async got=%h want=%h", obs, rst_v);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs !== rst_v) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, obs, rst_v);
            end
        end
        rst = 1'b1;
        n_ticks = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1);
            exp_v = model(n_ticks, 1'b1);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL reset_restart n=%0d got=%h want=%h", n_ticks, obs, exp_v);
            end
        end
    endtask

    task automatic test_short_frame();
        int hs_first, hs_cnt, vs_first, vs_cnt, fs_cnt, fs_first, fs_second;
        hs_first = -1; hs_cnt = 0; vs_first = -1; vs_cnt = 0;
        fs_cnt = 0; fs_first = -1; fs_second = -1;
        @(posedge clk);
        #1;
        rst_s = 1'b1;
        for (int t = 1; t <= 17700; t++) begin
            @(posedge clk);
            #1;
            if (t <= H_TOT && !hsync_s) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = t;
            end
            if (t <= 17600 && !vsync_s) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = t;
            end
            if (fs_s) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = t;
                else if (fs_second < 0) fs_second = t;
            end
            if (t == 2) begin
                checks++;
                if ({red_s, green_s, blue_s} !== 12'h5A5) begin
                    failures++;
                    $display("FAIL short_first_pixel got=%h want=5a5", {red_s, green_s, blue_s});
                end
            end
            if (t == 642) begin
                checks++;
                if ({red_s, green_s, blue_s} !== 12'h000) begin
                    failures++;
                    $display("FAIL short_hblank_rgb got=%h want=000", {red_s, green_s, blue_s});
                end
            end
            if (t == 15 * H_TOT + 640) begin
                checks++;
                if (addr_s !== 13'd159 || load_s !== 1'b1) begin
                    failures++;
                    $display("FAIL short_last_addr got=%0d/%0b want=159/1", addr_s, load_s);
                end
            end
        end
        checks++;
        if (hs_first != 658 || hs_cnt != 96) begin
            failures++;
            $display("FAIL hsync_timing got start=%0d len=%0d want 658/96", hs_first, hs_cnt);
        end
        checks++;
        if (vs_first != 14402 || vs_cnt != 1600) begin
            failures++;
            $display("FAIL vsync_timing got start=%0d len=%0d want 14402/1600", vs_first, vs_cnt);
        end
        checks++;
        if (fs_cnt != 2 || fs_first != 1 || fs_second != 17601) begin
            failures++;
            $display("FAIL frame_start got cnt=%0d at %0d,%0d want 2 at 1,17601",
                     fs_cnt, fs_first, fs_second);
        end
    endtask

    initial begin
        rst = 1'b0;
        rst_s = 1'b0;
        pix_en = 1'b0;
        mode_const = 1'b0;
        const_val = 12'h000;
        for (int i = 0; i < 8192; i++) mem[i] = 12'd0;
        test_reset();
        test_scan();
        test_blank_colour();
        test_pix_en();
        test_reset_mid();
        test_short_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
